// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the receiver and the transmitter.
package i2s_pkg;

    localparam int MAX_WIDTH_DEFAULT = 16;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } state_t;

    // A word length of 0 means 1; anything wider than the sample registers is capped.
    function automatic logic [7:0] clamp_word_length(input logic [7:0] requested, input int max_width);
        if (requested == 8'd0) return 8'd1;
        if (int'(requested) > max_width) return 8'(max_width);
        return requested;
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// Synchronises the three I2S pins into clk and flags rising edges of bit_clk.
module i2s_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic bit_clk,
    input  logic frame_clk,
    input  logic data,
    output logic frame_clk_sync,
    output logic data_sync,
    output logic bit_clk_rise
);

    // All three chains share one depth so ws and data stay aligned with the detected edge.
    logic [SYNC_STAGES-1:0] bit_clk_ff;
    logic [SYNC_STAGES-1:0] frame_clk_ff;
    logic [SYNC_STAGES-1:0] data_ff;
    logic                   bit_clk_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_clk_ff   <= '0;
            frame_clk_ff <= '0;
            data_ff      <= '0;
            bit_clk_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge value.
            bit_clk_ff   <= {bit_clk_ff[SYNC_STAGES-2:0], bit_clk};
            frame_clk_ff <= {frame_clk_ff[SYNC_STAGES-2:0], frame_clk};
            data_ff      <= {data_ff[SYNC_STAGES-2:0], data};
            bit_clk_prev <= bit_clk_ff[SYNC_STAGES-1];
        end
    end

    assign frame_clk_sync = frame_clk_ff[SYNC_STAGES-1];
    assign data_sync      = data_ff[SYNC_STAGES-1];
    assign bit_clk_rise   = bit_clk_ff[SYNC_STAGES-1] & ~bit_clk_prev;

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bit_clk/frame_clk/data on clk and deserialises
// left/right PCM words of programmable length.
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int MAX_WIDTH   = MAX_WIDTH_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           word_length,
    input  logic                 bit_clk,
    input  logic                 frame_clk,
    input  logic                 data,
    output logic [MAX_WIDTH-1:0] left_sample,
    output logic [MAX_WIDTH-1:0] right_sample,
    output logic                 sample_valid,
    output logic                 frame_error,
    output logic [7:0]           counter_out
);

    logic ws;
    logic d;
    logic rise;

    i2s_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge (
        .clk            (clk),
        .reset          (reset),
        .bit_clk        (bit_clk),
        .frame_clk      (frame_clk),
        .data           (data),
        .frame_clk_sync (ws),
        .data_sync      (d),
        .bit_clk_rise   (rise)
    );

    state_t               state, state_next;
    logic [7:0]           count, count_next;
    logic [7:0]           wl, wl_next;
    logic [MAX_WIDTH-1:0] shreg, shreg_next;
    logic [MAX_WIDTH-1:0] left_next, right_next;
    logic                 ws_prev, ws_prev_next;
    logic                 ws_seen, ws_seen_next;
    logic                 pair, pair_next;
    logic                 valid_next, error_next;

    logic                 ws_change;
    logic [MAX_WIDTH-1:0] word_bits;
    logic [8:0]           total;

    // ws_seen suppresses a false change on the very first edge after reset.
    assign ws_change = ws_seen && (ws != ws_prev);
    assign word_bits = (count < wl) ? {shreg[MAX_WIDTH-2:0], d} : shreg;
    assign total     = {1'b0, count} + 9'd1;

    always_comb begin
        // NOTE: every next value defaults to its current value first, so no latches are inferred.
        state_next   = state;
        count_next   = count;
        wl_next      = wl;
        shreg_next   = shreg;
        left_next    = left_sample;
        right_next   = right_sample;
        ws_prev_next = ws_prev;
        ws_seen_next = ws_seen;
        pair_next    = pair;
        valid_next   = 1'b0;
        error_next   = 1'b0;

        if (rise) begin
            ws_prev_next = ws;
            ws_seen_next = 1'b1;
            if (state != IDLE && !ws_change) begin
                shreg_next = word_bits;
                if (count != 8'hFF) count_next = count + 8'd1;
            end else if (ws_change) begin
                if (state != IDLE) begin
                    // The edge that flips ws still carries the closing slot's last bit.
                    if (total >= {1'b0, wl}) begin
                        if (state == LEFT) begin
                            left_next = word_bits;
                            pair_next = 1'b1;
                        end else begin
                            right_next = word_bits;
                            valid_next = pair;
                        end
                    end else begin
                        error_next = 1'b1;
                    end
                    if (state == RIGHT) pair_next = 1'b0;
                end
                state_next = (ws == WS_LEFT) ? LEFT : RIGHT;
                count_next = '0;
                shreg_next = '0;
                wl_next    = clamp_word_length(word_length, MAX_WIDTH);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            wl           <= 8'd1;
            shreg        <= '0;
            ws_prev      <= 1'b0;
            ws_seen      <= 1'b0;
            pair         <= 1'b0;
            left_sample  <= '0;
            right_sample <= '0;
            sample_valid <= 1'b0;
            frame_error  <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            wl           <= wl_next;
            shreg        <= shreg_next;
            ws_prev      <= ws_prev_next;
            ws_seen      <= ws_seen_next;
            pair         <= pair_next;
            left_sample  <= left_next;
            right_sample <= right_next;
            sample_valid <= valid_next;
            frame_error  <= error_next;
        end
    end

    assign counter_out = count;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: directed vector table, corner sequences and
// randomised slot streams scored against a slot-level reference model.
module tb_i2s_rx;

    localparam int MAXW = 16;
    localparam int LOW  = 4;
    localparam int HIGH = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [7:0]      word_length = 8'd4;
    logic            bit_clk = 1'b0;
    logic            frame_clk = 1'b0;
    logic            data = 1'b0;
    logic [MAXW-1:0] left_sample;
    logic [MAXW-1:0] right_sample;
    logic            sample_valid;
    logic            frame_error;
    logic [7:0]      counter_out;

    i2s_rx #(.MAX_WIDTH(MAXW), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .word_length  (word_length),
        .bit_clk      (bit_clk),
        .frame_clk    (frame_clk),
        .data         (data),
        .left_sample  (left_sample),
        .right_sample (right_sample),
        .sample_valid (sample_valid),
        .frame_error  (frame_error),
        .counter_out  (counter_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ws;
        int          len;
        logic [31:0] word;
    } slot_t;

    typedef struct {
        logic [7:0]  wl;
        int          len;
        logic [31:0] lword;
        logic [31:0] rword;
        int          frames;
        logic [15:0] exp_left;
        logic [15:0] exp_right;
        int          exp_valid;
        int          exp_ferr;
    } vec_t;

    slot_t       slots[$];
    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_fail = 0;
    int          valid_cnt = 0;
    int          ferr_cnt = 0;
    int          base_v, base_f;
    logic [15:0] exp_left, exp_right;
    int          exp_valid, exp_ferr;
    bit          pair;

    always @(negedge clk) begin
        if (sample_valid) valid_cnt <= valid_cnt + 1;
        if (frame_error)  ferr_cnt  <= ferr_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_edge(input logic ws, input logic d);
        @(negedge clk);
        frame_clk = ws;
        data = d;
        repeat (LOW) @(negedge clk);
        bit_clk = 1'b1;
        repeat (HIGH) @(negedge clk);
        bit_clk = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bit_clk = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic int clamp_wl(input int w);
        if (w == 0) return 1;
        if (w > MAXW) return MAXW;
        return w;
    endfunction

    // Reference: a closed slot keeps its first wl bits (MSB first) if it carried at least wl bits.
    task automatic model_close(input slot_t s, input int wl);
        logic [31:0] val;
        if (s.len < wl) begin
            exp_ferr++;
            if (s.ws) pair = 1'b0;
        end else begin
            val = (s.word >> (s.len - wl)) & ((32'd1 << wl) - 32'd1);
            if (!s.ws) begin
                exp_left = val[15:0];
                pair = 1'b1;
            end else begin
                exp_right = val[15:0];
                if (pair) exp_valid++;
                pair = 1'b0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check($sformatf("%s left", tag), 32'(left_sample), 32'(exp_left));
        check($sformatf("%s right", tag), 32'(right_sample), 32'(exp_right));
        check($sformatf("%s valid_count", tag), valid_cnt - base_v, exp_valid);
        check($sformatf("%s ferr_count", tag), ferr_cnt - base_f, exp_ferr);
    endtask

    // Sends a lead-in slot, every queued slot, then one closing edge; checks at each slot close.
    task automatic run_slots(input bit with_reset, input string tag);
        int   wl;
        logic pending;
        logic lead;
        if (with_reset) do_reset();
        wl = clamp_wl(int'(word_length));
        base_v = valid_cnt;
        base_f = ferr_cnt;
        exp_left = '0;
        exp_right = '0;
        exp_valid = 0;
        exp_ferr = 0;
        pair = 1'b0;
        pending = 1'b0;
        lead = ~slots[0].ws;
        drive_edge(lead, 1'b0);
        drive_edge(lead, 1'b0);
        for (int i = 0; i < slots.size(); i++) begin
            for (int k = 0; k < slots[i].len; k++) begin
                drive_edge(slots[i].ws, (k == 0) ? pending : slots[i].word[slots[i].len - k]);
                if (k == 0 && i > 0) begin
                    model_close(slots[i-1], wl);
                    check_model($sformatf("%s slot%0d", tag, i - 1));
                end
            end
            pending = slots[i].word[0];
        end
        drive_edge(~slots[slots.size()-1].ws, pending);
        model_close(slots[slots.size()-1], wl);
        check_model($sformatf("%s slot%0d", tag, slots.size() - 1));
    endtask

    task automatic push_slot(input logic ws, input int len, input logic [31:0] word);
        slot_t s;
        s.ws = ws;
        s.len = len;
        s.word = word;
        slots.push_back(s);
    endtask

    initial begin
        vecs[0] = '{8'd4,  4,  32'h0007, 32'h000D, 3, 16'h0007, 16'h000D, 3, 0};
        vecs[1] = '{8'd16, 16, 32'hA5C3, 32'h8001, 2, 16'hA5C3, 16'h8001, 2, 0};
        vecs[2] = '{8'd4,  16, 32'hBFFF, 32'h5FFF, 2, 16'h000B, 16'h0005, 2, 0};
        vecs[3] = '{8'd0,  8,  32'h0080, 32'h00C0, 2, 16'h0001, 16'h0001, 2, 0};
        vecs[4] = '{8'd40, 16, 32'h1234, 32'hFEDC, 2, 16'h1234, 16'hFEDC, 2, 0};
        vecs[5] = '{8'd40, 12, 32'h0ABC, 32'h0123, 1, 16'h0000, 16'h0000, 0, 2};

        do_reset();
        @(negedge clk);
        check("reset left", 32'(left_sample), 32'h0);
        check("reset right", 32'(right_sample), 32'h0);
        check("reset valid", 32'(sample_valid), 32'h0);
        check("reset ferr", 32'(frame_error), 32'h0);
        check("reset counter", 32'(counter_out), 32'h0);

        for (int v = 0; v < 6; v++) begin
            slots.delete();
            for (int f = 0; f < vecs[v].frames; f++) begin
                push_slot(1'b0, vecs[v].len, vecs[v].lword);
                push_slot(1'b1, vecs[v].len, vecs[v].rword);
            end
            word_length = vecs[v].wl;
            run_slots(1'b1, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table left", v), 32'(left_sample), 32'(vecs[v].exp_left));
            check($sformatf("vec%0d table right", v), 32'(right_sample), 32'(vecs[v].exp_right));
            check($sformatf("vec%0d table valid", v), valid_cnt - base_v, vecs[v].exp_valid);
            check($sformatf("vec%0d table ferr", v), ferr_cnt - base_f, vecs[v].exp_ferr);
        end

        // Short left slot: error pulse, left held, following right gives no pair.
        slots.delete();
        word_length = 8'd8;
        push_slot(1'b0, 8, 32'hAB);
        push_slot(1'b1, 8, 32'hCD);
        push_slot(1'b0, 5, 32'h1F);
        push_slot(1'b1, 8, 32'h12);
        run_slots(1'b1, "short");
        check("short left held", 32'(left_sample), 32'hAB);
        check("short right", 32'(right_sample), 32'h12);
        check("short valid", valid_cnt - base_v, 1);
        check("short ferr", ferr_cnt - base_f, 1);

        // Right-only start after reset.
        slots.delete();
        word_length = 8'd4;
        push_slot(1'b1, 4, 32'h9);
        push_slot(1'b0, 4, 32'h3);
        run_slots(1'b1, "ronly");
        check("ronly right", 32'(right_sample), 32'h9);
        check("ronly left", 32'(left_sample), 32'h3);
        check("ronly valid", valid_cnt - base_v, 0);

        // Reset halfway through a right slot.
        do_reset();
        word_length = 8'd8;
        begin
            logic [31:0] lw;
            logic [31:0] rw;
            lw = 32'h3C;
            rw = 32'h99;
            drive_edge(1'b1, 1'b0);
            drive_edge(1'b1, 1'b0);
            for (int k = 0; k < 8; k++) drive_edge(1'b0, (k == 0) ? 1'b0 : lw[8 - k]);
            for (int k = 0; k < 4; k++) drive_edge(1'b1, (k == 0) ? lw[0] : rw[8 - k]);
        end
        check("midrst left before", 32'(left_sample), 32'h3C);
        check("midrst counter before", 32'(counter_out), 32'h3);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst left after", 32'(left_sample), 32'h0);
        check("midrst right after", 32'(right_sample), 32'h0);
        check("midrst counter after", 32'(counter_out), 32'h0);
        slots.delete();
        push_slot(1'b0, 8, 32'h5A);
        push_slot(1'b1, 8, 32'h66);
        run_slots(1'b0, "midrst");
        check("midrst final left", 32'(left_sample), 32'h5A);
        check("midrst final right", 32'(right_sample), 32'h66);
        check("midrst final valid", valid_cnt - base_v, 1);

        // Randomised streams against the slot-level model.
        for (int r = 0; r < 6; r++) begin
            int   cwl;
            int   n;
            int   len;
            logic ws;
            slots.delete();
            word_length = 8'($urandom_range(0, 20));
            cwl = clamp_wl(int'(word_length));
            n = $urandom_range(4, 10);
            ws = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : $urandom_range(cwl, 20);
                push_slot(ws, len, $urandom & ((32'd1 << len) - 32'd1));
                ws = ~ws;
            end
            run_slots(1'b1, $sformatf("rand%0d", r));
        end

        // Stuck bit_clk: nothing moves.
        repeat (100) @(negedge clk);
        check_model("stuck");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
